// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: frame-rate serve/play/score/game-over sequencer for pong.
// Owns ball/paddle offsets, directions and scores; all updates are frame_tick
// qualified except the start edge detector, which samples every cycle.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   frame_tick              one-cycle per-frame update strobe
//   start                   serve/restart button (level, edge detected here)
//   btn_{L,R}_{up,dn}       paddle buttons
//   ball_detect_edge        active-low edge flags {left,top,right,bottom}
//   paddle_{R,L}_detect_edge  same encoding, per paddle
//   collision_detect        [0]/[1] x reach R/L, [2]/[5] y overlap R/L
//   ball_off_x/y            signed ball offsets
//   paddle_{R,L}_off_y      signed paddle offsets
//   score_L, score_R        scores
//   game_over, state_o      status

module pong_game_ctrl #(
    parameter int BALL_SPEED    = 4,
    parameter int PADDLE_SPEED  = 6,
    parameter int SERVE_FRAMES  = 60,
    parameter int SCORED_FRAMES = 30,
    parameter int WIN_SCORE     = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               btn_L_up,
    input  logic               btn_L_dn,
    input  logic               btn_R_up,
    input  logic               btn_R_dn,
    input  logic [3:0]         ball_detect_edge,
    input  logic [3:0]         paddle_R_detect_edge,
    input  logic [3:0]         paddle_L_detect_edge,
    input  logic [7:0]         collision_detect,
    output logic signed [31:0] ball_off_x,
    output logic signed [31:0] ball_off_y,
    output logic signed [31:0] paddle_R_off_y,
    output logic signed [31:0] paddle_L_off_y,
    output logic [3:0]         score_L,
    output logic [3:0]         score_R,
    output logic               game_over,
    output logic [2:0]         state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SERVE  = 3'd1,
        S_PLAY   = 3'd2,
        S_SCORED = 3'd3,
        S_OVER   = 3'd4
    } state_t;

    localparam logic [31:0] BS          = 32'(BALL_SPEED);
    localparam logic [31:0] PS          = 32'(PADDLE_SPEED);
    localparam logic [15:0] SERVE_LAST  = 16'(SERVE_FRAMES - 1);
    localparam logic [15:0] SCORED_LAST = 16'(SCORED_FRAMES - 1);
    localparam logic [3:0]  WIN         = 4'(WIN_SCORE);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [31:0] r_bx, w_bx_nxt;
    logic [31:0] r_by, w_by_nxt;
    logic [31:0] r_pl, w_pl_nxt;
    logic [31:0] r_pr, w_pr_nxt;
    logic [3:0]  r_sl, w_sl_nxt;
    logic [3:0]  r_sr, w_sr_nxt;
    // direction bits: 1 = positive step
    logic        r_dx, w_dx_nxt;
    logic        r_dy, w_dy_nxt;
    logic        r_start_q;

    logic        w_start_edge;
    logic        w_hit_r, w_hit_l, w_hit;
    logic        w_miss_r, w_miss_l;
    logic        w_dx_play, w_dy_play;
    logic [31:0] w_step_x, w_step_y;
    logic [31:0] w_pl_mv, w_pr_mv;

    function automatic logic [31:0] paddle_next(
        input logic [31:0] off,
        input logic        up,
        input logic        dn,
        input logic [3:0]  flags
    );
        paddle_next = off;
        if (up && !dn && flags[2]) begin
            paddle_next = off - PS;
        end else if (dn && !up && flags[0]) begin
            paddle_next = off + PS;
        end
    endfunction

    assign w_start_edge = start & ~r_start_q;

    // A hit only counts when the ball is travelling toward that paddle.
    assign w_hit_r  = r_dx & collision_detect[0] & collision_detect[2];
    assign w_hit_l  = ~r_dx & collision_detect[1] & collision_detect[5];
    assign w_hit    = w_hit_r | w_hit_l;
    assign w_miss_r = ~w_hit & ~ball_detect_edge[1];
    assign w_miss_l = ~w_hit & ball_detect_edge[1] & ~ball_detect_edge[3];

    assign w_dx_play = w_hit ? ~r_dx : r_dx;
    // Top flag wins if both vertical flags are low.
    assign w_dy_play = ~ball_detect_edge[2] ? 1'b1 :
                       ~ball_detect_edge[0] ? 1'b0 : r_dy;

    assign w_step_x = w_dx_play ? BS : (~BS + 32'd1);
    assign w_step_y = w_dy_play ? BS : (~BS + 32'd1);

    assign w_pl_mv = paddle_next(r_pl, btn_L_up, btn_L_dn,
                                 paddle_L_detect_edge);
    assign w_pr_mv = paddle_next(r_pr, btn_R_up, btn_R_dn,
                                 paddle_R_detect_edge);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bx_nxt    = r_bx;
        w_by_nxt    = r_by;
        w_pl_nxt    = r_pl;
        w_pr_nxt    = r_pr;
        w_sl_nxt    = r_sl;
        w_sr_nxt    = r_sr;
        w_dx_nxt    = r_dx;
        w_dy_nxt    = r_dy;

        unique case (r_state)
            S_IDLE: begin
                if (w_start_edge) begin
                    w_state_nxt = S_SERVE;
                    // a coincident tick is the first serve frame
                    w_cnt_nxt   = {15'd0, frame_tick};
                    w_dx_nxt    = 1'b1;
                    w_bx_nxt    = '0;
                    w_by_nxt    = '0;
                end
            end
            S_SERVE: begin
                if (frame_tick) begin
                    w_pl_nxt = w_pl_mv;
                    w_pr_nxt = w_pr_mv;
                    if (r_cnt == SERVE_LAST) begin
                        w_state_nxt = S_PLAY;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                    end
                end
            end
            S_PLAY: begin
                if (frame_tick) begin
                    w_pl_nxt = w_pl_mv;
                    w_pr_nxt = w_pr_mv;
                    w_dy_nxt = w_dy_play;
                    if (w_miss_r) begin
                        w_sl_nxt    = r_sl + 4'd1;
                        w_state_nxt = S_SCORED;
                        w_cnt_nxt   = '0;
                        w_dx_nxt    = 1'b1;
                    end else if (w_miss_l) begin
                        w_sr_nxt    = r_sr + 4'd1;
                        w_state_nxt = S_SCORED;
                        w_cnt_nxt   = '0;
                        w_dx_nxt    = 1'b0;
                    end else begin
                        w_dx_nxt = w_dx_play;
                        w_bx_nxt = r_bx + w_step_x;
                        w_by_nxt = r_by + w_step_y;
                    end
                end
            end
            S_SCORED: begin
                if (frame_tick) begin
                    w_pl_nxt = w_pl_mv;
                    w_pr_nxt = w_pr_mv;
                    if (r_cnt == SCORED_LAST) begin
                        w_cnt_nxt = '0;
                        if (r_sl == WIN || r_sr == WIN) begin
                            w_state_nxt = S_OVER;
                        end else begin
                            w_state_nxt = S_SERVE;
                            w_bx_nxt    = '0;
                            w_by_nxt    = '0;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                    end
                end
            end
            S_OVER: begin
                if (w_start_edge) begin
                    w_state_nxt = S_SERVE;
                    w_cnt_nxt   = {15'd0, frame_tick};
                    w_sl_nxt    = '0;
                    w_sr_nxt    = '0;
                    w_dx_nxt    = 1'b1;
                    w_dy_nxt    = 1'b1;
                    w_bx_nxt    = '0;
                    w_by_nxt    = '0;
                    w_pl_nxt    = '0;
                    w_pr_nxt    = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bx      <= '0;
            r_by      <= '0;
            r_pl      <= '0;
            r_pr      <= '0;
            r_sl      <= '0;
            r_sr      <= '0;
            r_dx      <= 1'b1;
            r_dy      <= 1'b1;
            r_start_q <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bx      <= w_bx_nxt;
            r_by      <= w_by_nxt;
            r_pl      <= w_pl_nxt;
            r_pr      <= w_pr_nxt;
            r_sl      <= w_sl_nxt;
            r_sr      <= w_sr_nxt;
            r_dx      <= w_dx_nxt;
            r_dy      <= w_dy_nxt;
            r_start_q <= start;
        end
    end

    assign ball_off_x     = r_bx;
    assign ball_off_y     = r_by;
    assign paddle_L_off_y = r_pl;
    assign paddle_R_off_y = r_pr;
    assign score_L        = r_sl;
    assign score_R        = r_sr;
    assign game_over      = (r_state == S_OVER);
    assign state_o        = r_state;

endmodule
